serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter N, default 8, meaning width of the assembled word (N >= 1).
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled only on rising clk.
REQ-004 SHALL have port s_valid  input  1  a serial bit is offered on s_bit.
REQ-005 SHALL have port s_bit  input  1  serial data bit, MSB of each word first.
REQ-006 SHALL have port s_ready  output  1  block will accept s_bit this cycle.
REQ-007 SHALL have port abort  input  1  synchronous discard of the partial frame.
REQ-008 SHALL have port data_out  output  N  assembled word; valid only while load_en=1.
REQ-009 SHALL have port load_en  output  1  one-cycle strobe for the downstream enable register.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port par_err  output  1  one-cycle parity-failure strobe.

Function
REQ-012 SHALL accept a bit only on a cycle with s_valid=1 and s_ready=1 (a transfer).
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (only when compiled in), LOAD.
REQ-014 IDLE: s_ready=1; on a transfer shift s_bit in, set the count to 1, go to SHIFT (or to PARITY/LOAD directly when N=1).
REQ-015 SHIFT: s_ready=1; on each transfer do shift_reg = {shift_reg[N-2:0], s_bit} and count+1; on the transfer that brings the count to N go to PARITY if compiled in, else LOAD.
REQ-016 SHIFT with s_valid=0 SHALL hold state, count and shift_reg unchanged (stalls of any length allowed).
REQ-017 LOAD: s_ready=0, load_en=1 for exactly one cycle, data_out = assembled word; next state IDLE.
REQ-018 Latency: load_en SHALL assert on the cycle immediately after the final accepted bit (data or parity).
REQ-019 load_en SHALL be 0 in every state except LOAD; consecutive frames yield load_en at most every N+1 cycles (N+2 with parity).
REQ-020 abort=1 in IDLE/SHIFT/PARITY SHALL return to IDLE with count=0 and no load_en; abort wins over a simultaneous final-bit transfer.
REQ-021 abort=1 in LOAD SHALL NOT suppress the load_en strobe of that cycle.
REQ-022 The count SHALL be ceil(log2(N+1)) bits wide and never exceed N.

Reset
REQ-023 reset=0 at a rising edge SHALL force IDLE, count=0, shift_reg=0, load_en=0, par_err=0, data_out=0, busy=0; s_ready=1 after reset.
REQ-024 reset SHALL take priority over abort and over any transfer, including mid-frame and during LOAD (strobe suppressed).

Configuration
REQ-025 Macro SERIAL_LOADER_PARITY_EN defined: after N data bits, one even-parity bit is accepted in PARITY state (s_ready=1).
REQ-026 With the macro, if XOR of data bits and parity bit is 1, the block SHALL pulse par_err for one cycle, skip LOAD, and return to IDLE; otherwise it goes to LOAD.
REQ-027 Macro undefined: PARITY state absent, par_err tied to 0, frame is exactly N bits.

Structure
REQ-028 State encodings and parity-mode constants SHALL live in shared package serial_loader_pkg.
REQ-029 The bit counter (clear, increment, terminal-count at N) SHALL be sub-module bit_counter.
REQ-030 data_out SHALL be driven directly from shift_reg; no output FIFO or extra buffering.

Verification
REQ-031 N=8, no parity: send 1,0,1,0,0,1,0,1 back-to-back -> load_en=1 exactly one cycle after the 8th transfer with data_out=8'hA5.
REQ-032 N=8: send 4 bits, s_valid=0 for 10 cycles, send 4 more -> single load_en; word correct; busy=1 throughout the stall.
REQ-033 N=8: abort asserted together with the 8th bit -> no load_en, state IDLE, next 8 bits 8'h3C -> data_out=8'h3C.
REQ-034 reset=0 asserted on the LOAD cycle -> load_en=0, all outputs zero on the following cycle, s_ready=1.
REQ-035 Parity build, N=8: 8'hA5 with parity bit 0 -> load_en, data_out=8'hA5; 8'hA5 with parity bit 1 -> par_err pulse, no load_en.
REQ-036 N=1: single bit 1 -> load_en on the next cycle with data_out=1'b1; chain to an 8-bit enable register and check it captures only on load_en.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// Shared state encoding and parity-mode constants for serial_loader.
// Define SERIAL_LOADER_PARITY_EN to append one even-parity bit to every frame.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StLoad   = 2'd3
  } state_e;

`ifdef SERIAL_LOADER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // XOR over data bits and the parity bit of a well-formed frame.
  localparam logic EvenParity = 1'b0;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter: synchronous clear, saturating increment at N, flags the (N-1)th bit.
module bit_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc;

  assign tc     = (cnt_q == W'(N));
  assign last_o = (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // rst_ni is sampled synchronously, like the parent's reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_loader.sv
// MSB-first serial-to-parallel loader producing a one-cycle load_en strobe per word.
// Optional even-parity bit per frame when SERIAL_LOADER_PARITY_EN is defined.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  input  logic         s_bit,
  output logic         s_ready,
  input  logic         abort,
  output logic [N-1:0] data_out,
  output logic         load_en,
  output logic         busy,
  output logic         par_err
);

  state_e       state_q;
  logic [N-1:0] shift_q, shift_d;
  logic         s_ready_q, load_en_q, busy_q, par_err_q;
  logic         xfer, last, par_ok, cnt_clr, cnt_inc;

  always_comb begin
    xfer    = s_valid && s_ready_q;
    shift_d = N'({shift_q, s_bit});
    par_ok  = (^shift_q ^ s_bit) == EvenParity;
    cnt_inc = xfer && !abort && (state_q == StIdle || state_q == StShift);
    cnt_clr = (abort && state_q != StLoad) || (state_q == StLoad) ||
              (state_q == StParity && xfer);
  end

  bit_counter #(
    .N (N)
  ) u_bit_counter (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      s_ready_q <= 1'b1;
      load_en_q <= 1'b0;
      busy_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      load_en_q <= 1'b0;
      par_err_q <= 1'b0;
      case (state_q)
        StIdle, StShift: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            shift_q <= shift_d;
            busy_q  <= 1'b1;
            if (!last) begin
              state_q <= StShift;
            end else if (ParityEn) begin
              state_q <= StParity;
            end else begin
              state_q   <= StLoad;
              load_en_q <= 1'b1;
              s_ready_q <= 1'b0;
            end
          end
        end
        StParity: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            if (par_ok) begin
              state_q   <= StLoad;
              load_en_q <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              par_err_q <= 1'b1;
            end
          end
        end
        // Strobe is already committed here, so abort has nothing left to cancel.
        StLoad: begin
          state_q   <= StIdle;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign load_en  = load_en_q;
  assign busy     = busy_q;
  assign par_err  = par_err_q;
  assign data_out = shift_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (N=8 and N=1 instances); honours SERIAL_LOADER_PARITY_EN.
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       reset, s_valid, s_bit, abort;
  logic       s_ready, load_en, busy, par_err;
  logic [7:0] data_out;

  logic       v1, b1, ab1;
  logic       rdy1, ld1, busy1, pe1;
  logic [0:0] d1;
  logic [7:0] en_reg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_loader #(.N(8)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_bit    (s_bit),
    .s_ready  (s_ready),
    .abort    (abort),
    .data_out (data_out),
    .load_en  (load_en),
    .busy     (busy),
    .par_err  (par_err)
  );

  serial_loader #(.N(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (v1),
    .s_bit    (b1),
    .s_ready  (rdy1),
    .abort    (ab1),
    .data_out (d1),
    .load_en  (ld1),
    .busy     (busy1),
    .par_err  (pe1)
  );

  // Downstream enable register fed by the N=1 loader.
  always_ff @(posedge clk) begin
    if (!reset) en_reg <= '0;
    else if (ld1) en_reg <= {7'b0, d1};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    s_valid = 1'b1;
    s_bit   = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send(w[i]);
  endtask

  task automatic send_parity(input logic p);
`ifdef SERIAL_LOADER_PARITY_EN
    send(p);
`else
    if (p === 1'bx) $display("parity bit ignored");
`endif
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_bit = 1'b0; abort = 1'b0;
    v1 = 1'b0; b1 = 1'b0; ab1 = 1'b0;
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_par_err", 32'(par_err), 32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back 8'hA5
    send_bits(8'hA5, 7, 1);
    check("a5_no_early_load", 32'(load_en), 32'd0);
    check("a5_busy", 32'(busy), 32'd1);
    send_bits(8'hA5, 0, 0);
    send_parity(1'b0);
    check("a5_load_en", 32'(load_en), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_s_ready_low", 32'(s_ready), 32'd0);
    check("a5_par_err", 32'(par_err), 32'd0);
    tick();
    check("a5_strobe_1cyc", 32'(load_en), 32'd0);
    check("a5_idle_busy", 32'(busy), 32'd0);
    check("a5_idle_ready", 32'(s_ready), 32'd1);

    // 4 bits, 10-cycle stall, 4 bits
    send_bits(8'h96, 7, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_load_en", 32'(load_en), 32'd0);
    end
    send_bits(8'h96, 3, 0);
    send_parity(1'b0);
    check("stall_load_en_final", 32'(load_en), 32'd1);
    check("stall_data", 32'(data_out), 32'h96);
    tick();
    check("stall_strobe_1cyc", 32'(load_en), 32'd0);

    // Abort together with the 8th bit, then a clean 8'h3C
    send_bits(8'hFF, 7, 1);
    s_valid = 1'b1; s_bit = 1'b1; abort = 1'b1;
    tick();
    s_valid = 1'b0; abort = 1'b0;
    check("abort_no_load", 32'(load_en), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd1);
    tick();
    check("abort_no_late_load", 32'(load_en), 32'd0);
    send_bits(8'h3C, 7, 0);
    send_parity(1'b0);
    check("post_abort_load", 32'(load_en), 32'd1);
    check("post_abort_data", 32'(data_out), 32'h3C);
    tick();

    // Reset asserted during LOAD
    send_bits(8'h5A, 7, 0);
    send_parity(1'b0);
    check("pre_rst_load", 32'(load_en), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("load_rst_load_en", 32'(load_en), 32'd0);
    check("load_rst_data", 32'(data_out), 32'h0);
    check("load_rst_busy", 32'(busy), 32'd0);
    check("load_rst_ready", 32'(s_ready), 32'd1);
    check("load_rst_par_err", 32'(par_err), 32'd0);
    tick();

`ifdef SERIAL_LOADER_PARITY_EN
    // Bad parity on 8'hA5
    send_bits(8'hA5, 7, 0);
    check("par_wait_no_load", 32'(load_en), 32'd0);
    check("par_wait_ready", 32'(s_ready), 32'd1);
    send(1'b1);
    check("par_err_pulse", 32'(par_err), 32'd1);
    check("par_err_no_load", 32'(load_en), 32'd0);
    check("par_err_idle", 32'(busy), 32'd0);
    tick();
    check("par_err_1cyc", 32'(par_err), 32'd0);
    check("par_err_no_late_load", 32'(load_en), 32'd0);
`else
    send_bits(8'hC3, 7, 0);
    check("nopar_load", 32'(load_en), 32'd1);
    check("nopar_data", 32'(data_out), 32'hC3);
    check("nopar_par_err", 32'(par_err), 32'd0);
    tick();
`endif

    // N=1 loader feeding the enable register
    check("n1_en_reg_init", 32'(en_reg), 32'h0);
    v1 = 1'b1; b1 = 1'b1;
    tick();
`ifdef SERIAL_LOADER_PARITY_EN
    tick();
`endif
    v1 = 1'b0;
    check("n1_load_en", 32'(ld1), 32'd1);
    check("n1_data", 32'(d1), 32'd1);
    check("n1_en_reg_before", 32'(en_reg), 32'h0);
    tick();
    check("n1_strobe_1cyc", 32'(ld1), 32'd0);
    check("n1_en_reg_cap", 32'(en_reg), 32'h1);
    tick();
    check("n1_en_reg_hold", 32'(en_reg), 32'h1);
    v1 = 1'b1; b1 = 1'b0;
    tick();
`ifdef SERIAL_LOADER_PARITY_EN
    tick();
`endif
    v1 = 1'b0;
    check("n1_load_en_2", 32'(ld1), 32'd1);
    check("n1_en_reg_before_2", 32'(en_reg), 32'h1);
    tick();
    check("n1_en_reg_cap_2", 32'(en_reg), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
